// File: rtl/deserializer.sv
// rtl/deserializer.sv - MSB-first serial-to-parallel receiver with bit-count and short-word flag
//
// Ports:
//   clk_i            clock, all logic on rising edge
//   arst_n_i         asynchronous active-low reset
//   ser_data_i       serial data bit, MSB of word first
//   ser_data_val_i   ser_data_i valid this cycle
//   deser_data_o     received word, left-aligned, unreceived LSBs are 0
//   deser_data_mod_o number of valid bits, 0 means a full DATA_W-bit word
//   deser_data_val_o one-cycle pulse, deser_data_o/deser_data_mod_o are new
//   deser_err_o      one-cycle pulse, a 1- or 2-bit word was discarded
//   busy_o           word in progress
module deserializer #(
    parameter int DATA_W     = 16,
    parameter int DATA_MOD_W = 4
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  ser_data_i,
    input  logic                  ser_data_val_i,
    output logic [DATA_W-1:0]     deser_data_o,
    output logic [DATA_MOD_W-1:0] deser_data_mod_o,
    output logic                  deser_data_val_o,
    output logic                  deser_err_o,
    output logic                  busy_o
);

    localparam logic [DATA_MOD_W:0]   CNT_LAST  = (DATA_MOD_W+1)'(DATA_W - 1);
    localparam logic [DATA_MOD_W:0]   CNT_MIN   = (DATA_MOD_W+1)'(3);
    localparam logic [DATA_MOD_W:0]   CNT_ONE   = (DATA_MOD_W+1)'(1);
    localparam logic [DATA_MOD_W-1:0] POS_TOP   = DATA_MOD_W'(DATA_W - 1);

    logic [DATA_W-1:0]     shreg;
    logic [DATA_MOD_W:0]   cnt;
    logic [DATA_W-1:0]     capture_word;
    logic [DATA_MOD_W-1:0] bit_pos;

    // Word as it looks once the current bit is stored. The first bit of a
    // word starts from zero so bits of an earlier word can never leak in.
    always_comb begin
        bit_pos      = POS_TOP - cnt[DATA_MOD_W-1:0];
        capture_word = (cnt == '0) ? '0 : shreg;
        capture_word[bit_pos] = ser_data_i;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            shreg            <= '0;
            cnt              <= '0;
            deser_data_o     <= '0;
            deser_data_mod_o <= '0;
            deser_data_val_o <= 1'b0;
            deser_err_o      <= 1'b0;
            busy_o           <= 1'b0;
        end else begin
            deser_data_val_o <= 1'b0;
            deser_err_o      <= 1'b0;
            if (ser_data_val_i) begin
                if (cnt == CNT_LAST) begin
                    // Last bit of a full word: emit directly from the
                    // capture path so the next cycle can start a new word.
                    deser_data_o     <= capture_word;
                    deser_data_mod_o <= '0;
                    deser_data_val_o <= 1'b1;
                    cnt              <= '0;
                    busy_o           <= 1'b0;
                end else begin
                    shreg  <= capture_word;
                    cnt    <= cnt + CNT_ONE;
                    busy_o <= 1'b1;
                end
            end else if (cnt != '0) begin
                if (cnt >= CNT_MIN) begin
                    deser_data_o     <= shreg;
                    deser_data_mod_o <= cnt[DATA_MOD_W-1:0];
                    deser_data_val_o <= 1'b1;
                end else begin
                    // 1- and 2-bit words are illegal on the link; drop them
                    // and leave the last good word on the outputs.
                    deser_err_o <= 1'b1;
                end
                cnt    <= '0;
                busy_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - directed self-checking bench for deserializer
module tb_deserializer;

    logic        clk_i = 1'b0;
    logic        arst_n_i = 1'b0;
    logic        ser_data_i = 1'b0;
    logic        ser_data_val_i = 1'b0;
    logic [15:0] deser_data_o;
    logic [3:0]  deser_data_mod_o;
    logic        deser_data_val_o;
    logic        deser_err_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_bad = 0;
    int val_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int val_snap;
    int err_snap;

    deserializer #(.DATA_W(16), .DATA_MOD_W(4)) dut (
        .clk_i            (clk_i),
        .arst_n_i         (arst_n_i),
        .ser_data_i       (ser_data_i),
        .ser_data_val_i   (ser_data_val_i),
        .deser_data_o     (deser_data_o),
        .deser_data_mod_o (deser_data_mod_o),
        .deser_data_val_o (deser_data_val_o),
        .deser_err_o      (deser_err_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (deser_data_val_o) val_cnt++;
        if (deser_err_o) err_cnt++;
        if (deser_data_val_o && deser_err_o) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic d);
        @(negedge clk_i);
        ser_data_val_i = v;
        ser_data_i     = d;
    endtask

    task automatic send_word(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) drive(1'b1, w[15-i]);
    endtask

    task automatic check_outs(input string tag, input logic [15:0] d, input logic [3:0] m,
                              input logic v, input logic e, input logic b);
        check({tag, ".data"}, 32'(deser_data_o), 32'(d));
        check({tag, ".mod"},  32'(deser_data_mod_o), 32'(m));
        check({tag, ".val"},  32'(deser_data_val_o), 32'(v));
        check({tag, ".err"},  32'(deser_err_o), 32'(e));
        check({tag, ".busy"}, 32'(busy_o), 32'(b));
    endtask

    initial begin
        logic [15:0] w2;
        #3;
        check_outs("reset", 16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        arst_n_i = 1'b1;
        drive(1'b0, 1'b0);

        // Full word, no gap
        send_word(16'hA5C3, 16);
        drive(1'b0, 1'b0);
        check_outs("full", 16'hA5C3, 4'h0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0);
        check("full.pulse_end", 32'(deser_data_val_o), 32'd0);

        // Back-to-back full words
        val_snap = val_cnt;
        err_snap = err_cnt;
        w2 = 16'hFEDC;
        send_word(16'h1234, 16);
        drive(1'b1, w2[15]);
        check_outs("b2b.first", 16'h1234, 4'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 16; i++) begin
            drive(1'b1, w2[15-i]);
            check("b2b.mid_val", 32'(deser_data_val_o), 32'd0);
        end
        drive(1'b0, 1'b0);
        check_outs("b2b.second", 16'hFEDC, 4'h0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0);
        check("b2b.val_pulses", 32'(val_cnt - val_snap), 32'd2);
        check("b2b.err_pulses", 32'(err_cnt - err_snap), 32'd0);

        // Partial word 1,0,1,1,0
        send_word(16'hB000, 5);
        drive(1'b0, 1'b0);
        check("part.busy", 32'(busy_o), 32'd1);
        check("part.no_val_yet", 32'(deser_data_val_o), 32'd0);
        drive(1'b0, 1'b0);
        check_outs("part", 16'hB000, 4'd5, 1'b1, 1'b0, 1'b0);

        // 2-bit short word: error, outputs keep previous word
        send_word(16'hC000, 2);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        check_outs("short2", 16'hB000, 4'd5, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0);
        check("short2.err_end", 32'(deser_err_o), 32'd0);

        // 1-bit short word
        send_word(16'h8000, 1);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        check_outs("short1", 16'hB000, 4'd5, 1'b0, 1'b1, 1'b0);

        // 3-bit word is legal
        send_word(16'hE000, 3);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        check_outs("min3", 16'hE000, 4'd3, 1'b1, 1'b0, 1'b0);

        // Reset mid-word
        send_word(16'hFFFF, 7);
        @(posedge clk_i);
        #2;
        ser_data_val_i = 1'b0;
        arst_n_i = 1'b0;
        #1;
        check_outs("rst_mid", 16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        arst_n_i = 1'b1;
        drive(1'b0, 1'b0);
        val_snap = val_cnt;
        err_snap = err_cnt;
        send_word(16'h0F0F, 16);
        drive(1'b0, 1'b0);
        check_outs("after_rst", 16'h0F0F, 4'h0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0);
        check("after_rst.val_pulses", 32'(val_cnt - val_snap), 32'd1);
        check("after_rst.err_pulses", 32'(err_cnt - err_snap), 32'd0);

        // Idle: outputs hold, no pulses
        val_snap = val_cnt;
        err_snap = err_cnt;
        repeat (20) drive(1'b0, 1'b1);
        check_outs("idle", 16'h0F0F, 4'h0, 1'b0, 1'b0, 1'b0);
        check("idle.val_pulses", 32'(val_cnt - val_snap), 32'd0);
        check("idle.err_pulses", 32'(err_cnt - err_snap), 32'd0);

        // 4-bit word after idle: no stale bits
        send_word(16'h9000, 4);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        check_outs("fresh4", 16'h9000, 4'd4, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0);
        check("val_err_exclusive", 32'(both_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Receive side of the team's serial link. Collects an MSB-first bit stream, qualified by a valid strobe, back into parallel words of up to DATA_W bits.
- A word ends when DATA_W bits have arrived, or when the valid strobe drops after at least one bit.
- Emits the left-aligned word plus a bit count, using the same count encoding as the transmit side (0 means a full DATA_W-bit word).
- Illegal short words of 1 or 2 bits are dropped and flagged.

Parameters:
DATA_W, 16, maximum word width in bits
DATA_MOD_W, 4, width of bit-count field; DATA_W must equal 2**DATA_MOD_W

Ports:
clk_i  input  1  clock, all logic on rising edge
arst_n_i  input  1  asynchronous active-low reset
ser_data_i  input  1  serial data bit, MSB of word first
ser_data_val_i  input  1  ser_data_i valid this cycle
deser_data_o  output  DATA_W  received word, left-aligned; unreceived LSBs are 0
deser_data_mod_o  output  DATA_MOD_W  number of valid bits; 0 = DATA_W bits
deser_data_val_o  output  1  one-cycle pulse: deser_data_o/deser_data_mod_o are new
deser_err_o  output  1  one-cycle pulse: a 1- or 2-bit word was received and discarded
busy_o  output  1  word in progress (at least 1 bit collected, not yet terminated)

Behaviour:
- Reset (arst_n_i low, asynchronous, release synchronous to clk_i):
  - All outputs are 0.
  - Internal shift register and bit counter (DATA_MOD_W+1 bits) are 0.
  - A partial word in progress is discarded.
- Bit capture: on each edge with ser_data_val_i=1, store ser_data_i at bit position DATA_W-1-cnt, then cnt += 1.
  - The first bit of a word always clears the shift register before storing, so stale bits never leak into a new word.
- busy_o is registered: 1 from the edge after the first bit until the edge that terminates the word.
- Full-word termination: at the edge sampling bit number DATA_W (cnt==DATA_W-1 and valid=1):
  - deser_data_o = full word; deser_data_mod_o = 0; deser_data_val_o = 1 for one cycle; cnt = 0; busy_o = 0.
  - If valid stays high on the next cycle, that bit starts a new word. Back-to-back full words need no gap.
- Gap termination: at an edge with ser_data_val_i=0 and cnt>0:
  - If cnt >= 3: deser_data_o = collected bits, MSB-aligned, lower DATA_W-cnt bits 0; deser_data_mod_o = cnt[DATA_MOD_W-1:0]; deser_data_val_o pulses.
  - If cnt is 1 or 2: data outputs are not updated, deser_data_val_o stays 0, deser_err_o pulses for one cycle.
  - In both cases cnt = 0 and busy_o = 0.
- ser_data_val_i=0 with cnt==0: nothing happens (idle).
- Latency: outputs change at the same edge that samples the terminating condition and are visible the following cycle.
- deser_data_o and deser_data_mod_o hold their last value between pulses. They are never cleared except by reset.
- deser_data_val_o and deser_err_o are never high in the same cycle.
- ser_data_i is ignored when ser_data_val_i=0.
- Reset asserted mid-word: word lost, no pulse; the first valid bit after release starts a new word at position DATA_W-1.

Test Plan:
- Full word, no gap: 16 valid bits of 0xA5C3 MSB-first. Required:
  - deser_data_o = 0xA5C3, mod = 0, val pulse one cycle after the 16th bit edge.
  - busy_o = 0 after the pulse.
- Back-to-back full words: 32 bits 0x1234 then 0xFEDC, valid continuously high. Required: two pulses 16 cycles apart with the correct words, no err.
- Partial word: 5 bits 1,0,1,1,0 then valid low. Required: deser_data_o = 0xB000, mod = 5, val pulse at the gap edge.
- Short words:
  - 2 bits then gap: err pulse, no val, data outputs keep previous value.
  - 1 bit then gap: err pulse.
  - 3 bits 1,1,1 then gap: val, data = 0xE000, mod = 3.
- Reset mid-word: 7 bits, then arst_n_i low for 2 cycles mid-cycle (asynchronous). Required:
  - All outputs 0 immediately.
  - After release, 16 bits of 0x0F0F yield exactly one pulse with 0x0F0F.
- Idle and stale data: valid low for 20 cycles after a word. Required:
  - No pulses; data and mod outputs hold.
  - A following 4-bit word 1,0,0,1 gives 0x9000 with no leftover bits from the earlier word.
